// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states, PC-source
// selections and a counter-width helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PUSH  = 2'd1,
    ST_POP   = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_e;

  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_STACK  = 2'b01;
  localparam logic [1:0] PC_SRC_VECTOR = 2'b10;

  // A one-step counter still needs a 1-bit register.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Wrap counter 0..LIMIT-1 with synchronous clear and enable; last_o flags the final step
// so the sequencer can leave its state exactly when the counter wraps back to 0.
module seq_step_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter  int LIMIT = 2,
  localparam int W     = cnt_width(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  assign last_o  = (count_q == W'(LIMIT - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = last_o ? '0 : count_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr_i) count_q <= '0;
    else              count_q <= count_d;
  end

endmodule

// File: rtl/pipeline_sequence_controller.sv
// Central stall/flush sequencer: load-use stalls, CALL/interrupt PC push, RET/RTI PC pop
// through the narrow data memory, and the flush window after every PC redirect.
module pipeline_sequence_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int MEM_WORD    = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hazard_load,
  input  logic       mem_call,
  input  logic       mem_ret,
  input  logic       mem_rti,
  input  logic       int_req,
  output logic       freeze_pc,
  output logic       freeze_ifid,
  output logic       bubble_idex,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic [1:0] pc_src,
  output logic       stack_active,
  output logic       stack_pop,
  output logic       stack_word,
  output logic       restore_flags,
  output logic       int_ack
);

  localparam int NWORDS = PC_WIDTH / MEM_WORD;
  localparam int WCW    = cnt_width(NWORDS);
  localparam int FCW    = cnt_width(FLUSH_DEPTH);

  seq_state_e     state_q, state_d;
  logic           is_int_q, is_int_d;
  logic           is_rti_q, is_rti_d;
  logic           int_pending_q, int_pending_d;
  logic           accept;
  logic           in_stack, in_flush;
  logic [WCW-1:0] wcnt;
  logic [FCW-1:0] fcnt;
  logic           w_last, f_last;

  assign in_stack = (state_q == ST_PUSH) || (state_q == ST_POP);
  assign in_flush = (state_q == ST_FLUSH);

  seq_step_counter #(.LIMIT(NWORDS)) u_wcnt (
    .clk(clk), .rst(rst), .clr_i(!in_stack), .en_i(in_stack),
    .count_o(wcnt), .last_o(w_last)
  );

  seq_step_counter #(.LIMIT(FLUSH_DEPTH)) u_fcnt (
    .clk(clk), .rst(rst), .clr_i(!in_flush), .en_i(in_flush),
    .count_o(fcnt), .last_o(f_last)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d       = state_q;
    is_int_d      = is_int_q;
    is_rti_d      = is_rti_q;
    accept        = 1'b0;
    freeze_pc     = 1'b0;
    freeze_ifid   = 1'b0;
    bubble_idex   = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    pc_src        = PC_SRC_NEXT;
    stack_active  = 1'b0;
    stack_pop     = 1'b0;
    stack_word    = 1'b0;
    restore_flags = 1'b0;
    int_ack       = 1'b0;

    // Outputs are gated during reset so a sequence caught mid-flight drives nothing.
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_ret || mem_call || int_pending_q || hazard_load) begin
            freeze_pc   = 1'b1;
            freeze_ifid = 1'b1;
            bubble_idex = 1'b1;
          end
          if (mem_ret) begin
            state_d  = ST_POP;
            is_rti_d = mem_rti;
          end else if (mem_call) begin
            state_d  = ST_PUSH;
            is_int_d = 1'b0;
          end else if (int_pending_q) begin
            state_d  = ST_PUSH;
            is_int_d = 1'b1;
            int_ack  = 1'b1;
            accept   = 1'b1;
          end
        end
        ST_PUSH: begin
          stack_active = 1'b1;
          stack_word   = wcnt[0];
          freeze_pc    = 1'b1;
          freeze_ifid  = 1'b1;
          bubble_idex  = 1'b1;
          if (w_last) begin
            if (is_int_q) begin
              freeze_pc = 1'b0;
              pc_src    = PC_SRC_VECTOR;
              state_d   = ST_FLUSH;
            end else begin
              state_d   = ST_RUN;
            end
          end
        end
        ST_POP: begin
          stack_active = 1'b1;
          stack_pop    = 1'b1;
          stack_word   = wcnt[0];
          freeze_ifid  = 1'b1;
          bubble_idex  = 1'b1;
          freeze_pc    = !w_last;
          if (w_last) begin
            pc_src        = PC_SRC_STACK;
            restore_flags = is_rti_q;
            state_d       = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (f_last) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    int_pending_d = accept ? 1'b0 : (int_pending_q | int_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      is_int_q      <= 1'b0;
      is_rti_q      <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_int_q      <= is_int_d;
      is_rti_q      <= is_rti_d;
      int_pending_q <= int_pending_d;
    end
  end

  a_call_ret_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_call && mem_ret));
  a_call_ret_only_in_run: assert property (@(posedge clk) disable iff (rst)
    (state_q != ST_RUN) |-> !(mem_call || mem_ret));
  a_wcnt_in_range: assert property (@(posedge clk) disable iff (rst)
    wcnt <= WCW'(NWORDS - 1));
  a_fcnt_in_range: assert property (@(posedge clk) disable iff (rst)
    fcnt <= FCW'(FLUSH_DEPTH - 1));

endmodule
